// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the VGA raster timing generator.
// The region enum, the 640x480@60 defaults, counter widths and the debug struct live here.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } region_t;

  localparam int H_W = 12;
  localparam int V_W = 11;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Live view of both region FSMs and the wrap strobes for checkers.
  typedef struct packed {
    region_t h_region;
    region_t v_region;
    logic    line_end;
    logic    frame_end;
  } vga_dbg_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus the region FSM that follows it.
// wrap is high while the count sits on its last position, so a step there returns it to 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = 640,
  parameter int FP_LEN     = 16,
  parameter int SYNC_LEN   = 96,
  parameter int BP_LEN     = 48,
  parameter int W          = 12
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         step,
  output logic [W-1:0] cnt,
  output region_t      region,
  output logic         wrap
);

  localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;

  localparam logic [W-1:0] END_ACTIVE = W'(ACTIVE_LEN - 1);
  localparam logic [W-1:0] END_FP     = W'(ACTIVE_LEN + FP_LEN - 1);
  localparam logic [W-1:0] END_SYNC   = W'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);

  region_t region_q;
  region_t region_d;

  assign wrap   = (cnt == LAST);
  assign region = region_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      region_q <= ACTIVE;
    end else begin
      region_q <= region_d;
    end
  end

  // Each region is left on the step taken from its final position.
  always_comb begin
    region_d = region_q;
    if (step) begin
      case (region_q)
        ACTIVE:  if (cnt == END_ACTIVE) region_d = FRONT;
        FRONT:   if (cnt == END_FP)     region_d = SYNC;
        SYNC:    if (cnt == END_SYNC)   region_d = BACK;
        BACK:    if (cnt == LAST)       region_d = ACTIVE;
        default: region_d = ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: registered active-low Hsync/Vsync, DE and a start-of-frame pulse.
// Defining VGA_TIMING_COORD_EN adds X/Y pixel coordinates registered alongside DE.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           EN,
  output logic           Hsync,
  output logic           Vsync,
  output logic           DE,
`ifdef VGA_TIMING_COORD_EN
  output logic [H_W-1:0] X,
  output logic [V_W-1:0] Y,
`endif
  output logic           SOF,
  output vga_dbg_t       dbg
);

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  region_t        h_region;
  region_t        v_region;
  logic           h_wrap;
  logic           v_wrap;
  logic           visible;

  vga_axis_counter #(
    .ACTIVE_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .W(H_W)
  ) u_h (
    .CLK(CLK), .RESET(RESET), .step(EN),
    .cnt(h), .region(h_region), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .W(V_W)
  ) u_v (
    .CLK(CLK), .RESET(RESET), .step(EN & h_wrap),
    .cnt(v), .region(v_region), .wrap(v_wrap)
  );

  assign visible = (h_region == ACTIVE) && (v_region == ACTIVE);

  assign dbg.h_region  = h_region;
  assign dbg.v_region  = v_region;
  assign dbg.line_end  = h_wrap;
  assign dbg.frame_end = h_wrap & v_wrap;

  // Outputs describe the pixel the counters held before this edge's increment.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Hsync <= 1'b1;
      Vsync <= 1'b1;
      DE    <= 1'b0;
      SOF   <= 1'b0;
    end else if (EN) begin
      Hsync <= (h_region != SYNC);
      Vsync <= (v_region != SYNC);
      DE    <= visible;
      SOF   <= (h == '0) && (v == '0);
    end
  end

`ifdef VGA_TIMING_COORD_EN
  // Coordinates only move on visible pixels, so blanking shows the last one.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      X <= '0;
      Y <= '0;
    end else if (EN && visible) begin
      X <= h;
      Y <= v;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance checked over one line plus a mid-line reset,
// and a 12x7 instance checked cycle by cycle against a small reference model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_d, rst_s, EN;
  logic hs_d, vs_d, de_d, sof_d;
  logic hs_s, vs_s, de_s, sof_s;
  vga_dbg_t dbg_d, dbg_s;
`ifdef VGA_TIMING_COORD_EN
  logic [11:0] x_d, x_s;
  logic [10:0] y_d, y_s;
`endif

  int total = 0;
  int bad   = 0;

  vga_timing_gen dut_d (
    .CLK(CLK), .RESET(rst_d), .EN(EN),
    .Hsync(hs_d), .Vsync(vs_d), .DE(de_d),
`ifdef VGA_TIMING_COORD_EN
    .X(x_d), .Y(y_d),
`endif
    .SOF(sof_d), .dbg(dbg_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_s (
    .CLK(CLK), .RESET(rst_s), .EN(EN),
    .Hsync(hs_s), .Vsync(vs_s), .DE(de_s),
`ifdef VGA_TIMING_COORD_EN
    .X(x_s), .Y(y_s),
`endif
    .SOF(sof_s), .dbg(dbg_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model of the 12x7 instance (visible 8x4, hsync h=9..10, vsync v=5).
  int hm, vm;
  logic e_de, e_hs, e_vs, e_sof;
  logic [11:0] e_x;
  logic [10:0] e_y;

  task automatic model_reset();
    hm = 0; vm = 0;
    e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_sof = 1'b0;
    e_x = '0; e_y = '0;
  endtask

  task automatic model_step();
    e_de  = (hm < 8) && (vm < 4);
    e_hs  = !((hm >= 9) && (hm < 11));
    e_vs  = !(vm == 5);
    e_sof = (hm == 0) && (vm == 0);
    if (e_de) begin
      e_x = 12'(hm);
      e_y = 11'(vm);
    end
    if (hm == 11) begin
      hm = 0;
      vm = (vm == 6) ? 0 : vm + 1;
    end else begin
      hm = hm + 1;
    end
  endtask

  task automatic check_s(input string tag);
    check({tag, "_de"},  de_s,  e_de);
    check({tag, "_hs"},  hs_s,  e_hs);
    check({tag, "_vs"},  vs_s,  e_vs);
    check({tag, "_sof"}, sof_s, e_sof);
`ifdef VGA_TIMING_COORD_EN
    check({tag, "_x"}, x_s, e_x);
    check({tag, "_y"}, y_s, e_y);
`endif
  endtask

  task automatic s_cycle(input logic en_v, input string tag);
    EN = en_v;
    tick();
    if (en_v) model_step();
    check_s(tag);
  endtask

  int de_cnt, hs_low, vs_low, last_sof, first_hs;

  initial begin
    rst_d = 1'b1; rst_s = 1'b1; EN = 1'b1;
    model_reset();
    repeat (3) tick();

    check("rst_d_hs", hs_d, 1); check("rst_d_vs", vs_d, 1);
    check("rst_d_de", de_d, 0); check("rst_d_sof", sof_d, 0);
    check_s("rst_s");

    // Default timing: one full line from reset release.
    rst_d = 1'b0;
    tick();
    check("d_first_de", de_d, 1); check("d_first_sof", sof_d, 1);
    check("d_first_hs", hs_d, 1); check("d_first_vs", vs_d, 1);
    de_cnt = 1; hs_low = 0; first_hs = -1;
    for (int k = 1; k < 800; k++) begin
      tick();
      check("d_line_de", de_d, (k < 640) ? 1 : 0);
      check("d_line_hs", hs_d, ((k >= 656) && (k < 752)) ? 0 : 1);
      check("d_line_sof", sof_d, 0);
      check("d_line_vs", vs_d, 1);
      if (de_d) de_cnt++;
      if (!hs_d) begin
        hs_low++;
        if (first_hs < 0) first_hs = k;
      end
`ifdef VGA_TIMING_COORD_EN
      if (k == 639) begin
        check("d_last_x", x_d, 639); check("d_last_y", y_d, 0);
      end
      if (k == 799) begin
        check("d_blank_x", x_d, 639); check("d_blank_y", y_d, 0);
      end
`endif
    end
    check("d_de_count", de_cnt, 640);
    check("d_hs_low_count", hs_low, 96);
    check("d_hs_fall", first_hs, 656);

    // Into line 1 up to pixel 700, which sits inside hsync, then reset between edges.
    for (int k = 0; k <= 700; k++) tick();
    check("d_pre_rst_hs", hs_d, 0);
    check("d_pre_rst_de", de_d, 0);
    #2 rst_d = 1'b1;
    #1;
    check("d_async_hs", hs_d, 1); check("d_async_vs", vs_d, 1);
    check("d_async_de", de_d, 0); check("d_async_sof", sof_d, 0);
    tick();
    rst_d = 1'b0;
    tick();
    check("d_restart_de", de_d, 1); check("d_restart_sof", sof_d, 1);
    rst_d = 1'b1;

    // Small 12x7 instance: two frames with EN held high.
    rst_s = 1'b0;
    de_cnt = 0; vs_low = 0; last_sof = -1;
    for (int c = 0; c < 168; c++) begin
      s_cycle(1'b1, "s_run");
      if (c < 84) begin
        if (de_s) de_cnt++;
        if (!vs_s) vs_low++;
      end
      if (c == 82) begin
        check("s_frame_end", dbg_s.frame_end, 1);
        check("s_h_back", dbg_s.h_region, BACK);
        check("s_v_back", dbg_s.v_region, BACK);
      end
      if (c == 84) check("s_sof_after_wrap", sof_s, 1);
      if (sof_s) begin
        if (last_sof >= 0) check("s_sof_period", c - last_sof, 84);
        last_sof = c;
      end
`ifdef VGA_TIMING_COORD_EN
      if (c == 83) begin
        check("s_blank_x", x_s, 7); check("s_blank_y", y_s, 3);
      end
`endif
    end
    check("s_de_count", de_cnt, 32);
    check("s_vs_low_count", vs_low, 12);

    // Random 50% enable: per enabled cycle identical, held otherwise.
    for (int c = 0; c < 400; c++) s_cycle(1'($urandom_range(0, 1)), "s_rand");

    // Stall exactly on the double wrap, then let it complete.
    for (int i = 0; i < 200 && !(hm == 11 && vm == 6); i++) s_cycle(1'b1, "s_seek_wrap");
    check("s_reach_wrap", (hm == 11 && vm == 6) ? 1 : 0, 1);
    s_cycle(1'b0, "s_stall");
    s_cycle(1'b0, "s_stall");
    s_cycle(1'b1, "s_last_pix");
    s_cycle(1'b1, "s_deferred_wrap");
    check("s_sof_deferred", sof_s, 1);
    s_cycle(1'b0, "s_hold");
    check("s_sof_held", sof_s, 1);
    s_cycle(1'b0, "s_hold");
    check("s_sof_held2", sof_s, 1);

    // Mid-frame reset at h=10, v=3.
    for (int i = 0; i < 200 && !(hm == 10 && vm == 3); i++) s_cycle(1'b1, "s_seek_mid");
    check("s_reach_mid", (hm == 10 && vm == 3) ? 1 : 0, 1);
    #2 rst_s = 1'b1;
    #1;
    model_reset();
    check_s("s_async");
    tick();
    rst_s = 1'b0;
    s_cycle(1'b1, "s_restart");
    check("s_restart_sof", sof_s, 1);
    for (int c = 0; c < 90; c++) s_cycle(1'b1, "s_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
